// File: rtl/meas_sequencer.sv
// rtl/meas_sequencer.sv - measurement frame sequencer: clear, gate, settle, then latch/shift four channels
// Optional channel skipping is enabled by defining MEAS_SEQ_CHANNEL_MASK_EN.
module meas_sequencer #(
  parameter int GATE_W        = 16,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SHIFT_CYCLES  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
`ifdef MEAS_SEQ_CHANNEL_MASK_EN
  input  logic [3:0]        chan_mask,
`endif
  output logic              ctr_reset,
  output logic              gate,
  output logic              latch_counter,
  output logic [1:0]        counter_select,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (GATE_W > 16) ? GATE_W : 16;
  localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LD  = CW'(SHIFT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH, S_SHIFT, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_nxt;
  logic [GATE_W-1:0] r_gate_q;
  logic [GATE_W-1:0] w_gate_m1;
  logic              w_capture;
  logic              w_cnt_zero;
  logic [3:0]        w_mask;
  logic [2:0]        w_from;
  logic [2:0]        w_chan;
  logic              r_ctr_reset;
  logic              r_gate;
  logic              r_latch;
  logic              r_busy;
  logic              r_done;

`ifdef MEAS_SEQ_CHANNEL_MASK_EN
  logic [3:0] r_mask;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= 4'h0;
    end else if (ena && w_capture) begin
      r_mask <= chan_mask;
    end
  end
  assign w_mask = r_mask;
`else
  assign w_mask = 4'hF;
`endif

  // Lowest enabled channel at or above 'from'; bit 2 set means none left.
  function automatic logic [2:0] next_chan(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

  // Loading gate_q-1 makes gate_q==0 wrap to the full 2^GATE_W window.
  assign w_gate_m1  = r_gate_q - GATE_W'(1);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_from     = (r_state == S_SHIFT) ? ({1'b0, r_idx} + 3'd1) : 3'd0;
  assign w_chan     = next_chan(w_mask, w_from);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CW'(1);
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = RST_LD;
          w_idx_nxt   = 2'd0;
          w_capture   = 1'b1;
        end
      end
      S_CLEAR: if (w_cnt_zero) begin
        w_state_nxt = S_GATE;
        w_cnt_nxt   = CW'(w_gate_m1);
      end
      S_GATE: if (w_cnt_zero) begin
        w_state_nxt = S_SETTLE;
        w_cnt_nxt   = SETTLE_LD;
      end
      S_SETTLE, S_SHIFT: if (w_cnt_zero) begin
        if (w_chan[2]) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LATCH;
          w_idx_nxt   = w_chan[1:0];
        end
      end
      S_LATCH: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = SHIFT_LD;
      end
      S_DONE: begin
        w_idx_nxt = 2'd0;
        if (continuous) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = RST_LD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_gate_q    <= '0;
      r_ctr_reset <= 1'b0;
      r_gate      <= 1'b0;
      r_latch     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (ena) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      if (w_capture) r_gate_q <= gate_len;
      r_ctr_reset <= (w_state_nxt == S_CLEAR);
      r_gate      <= (w_state_nxt == S_GATE);
      r_latch     <= (w_state_nxt == S_LATCH);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign ctr_reset      = r_ctr_reset;
  assign gate           = r_gate;
  assign latch_counter  = r_latch;
  assign counter_select = r_idx;
  assign busy           = r_busy;
  assign frame_done     = r_done;

endmodule

// File: tb/tb_meas_sequencer.sv
// tb/tb_meas_sequencer.sv - randomized scoreboard bench for meas_sequencer
module tb_meas_sequencer;
  localparam int GATE_W = 16;
  localparam int RST_C  = 4;
  localparam int SET_C  = 4;
  localparam int SH_C   = 24;
  localparam int K_CLR = 0, K_GATE = 1, K_LATCH = 2, K_DONE = 3, K_BUSY = 4;
  localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;
`ifdef MEAS_SEQ_CHANNEL_MASK_EN
  localparam bit HAS_MASK = 1'b1;
`else
  localparam bit HAS_MASK = 1'b0;
`endif

  typedef struct {
    int     kind;
    longint cyc;
    longint val;
  } ev_t;
  ev_t exp_q[$];

  logic clk = 1'b0, reset = 1'b1, ena = 1'b1, start = 1'b0, continuous = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;
  logic [3:0] chan_mask = 4'hF;
  logic ctr_reset, gate, latch_counter, busy, frame_done;
  logic [1:0] counter_select;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;

  meas_sequencer #(.GATE_W(GATE_W), .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .SHIFT_CYCLES(SH_C)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .continuous(continuous), .gate_len(gate_len),
`ifdef MEAS_SEQ_CHANNEL_MASK_EN
    .chan_mask(chan_mask),
`endif
    .ctr_reset(ctr_reset), .gate(gate), .latch_counter(latch_counter),
    .counter_select(counter_select), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic got(input int kind, input longint c, input longint v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d value %0d, expected none", kind, c, v);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("ev_kind@%0d", c), 64'(kind), 64'(e.kind));
    check($sformatf("ev_cycle k%0d", e.kind), 64'(c), 64'(e.cyc));
    check($sformatf("ev_value k%0d@%0d", e.kind, e.cyc), 64'(v), 64'(e.val));
  endtask

  // Monitor: turns output activity into events and checks them against the queue.
  logic p_clr = 1'b0, p_gate = 1'b0, p_busy = 1'b0, p_latch = 1'b0, p_done = 1'b0;
  longint s_clr = 0, s_gate = 0, s_busy = 0;
  always @(negedge clk) begin
    if (ctr_reset === 1'b1 && !p_clr) s_clr = cyc;
    if (ctr_reset !== 1'b1 && p_clr) got(K_CLR, s_clr, cyc - s_clr);
    if (gate === 1'b1 && !p_gate) s_gate = cyc;
    if (gate !== 1'b1 && p_gate) got(K_GATE, s_gate, cyc - s_gate);
    if (busy === 1'b1 && !p_busy) s_busy = cyc;
    if (busy !== 1'b1 && p_busy) got(K_BUSY, s_busy, cyc - s_busy);
    if (latch_counter === 1'b1 && !p_latch) got(K_LATCH, cyc, longint'(counter_select));
    if (frame_done === 1'b1 && !p_done) got(K_DONE, cyc, 0);
    if ((int'(ctr_reset) + int'(gate) + int'(latch_counter)) > 1) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap@%0d: clr=%b gate=%b latch=%b, at most one high", cyc, ctr_reset, gate, latch_counter);
    end
    p_clr   = (ctr_reset === 1'b1);
    p_gate  = (gate === 1'b1);
    p_busy  = (busy === 1'b1);
    p_latch = (latch_counter === 1'b1);
    p_done  = (frame_done === 1'b1);
  end

  task automatic push(input int kind, input longint c, input longint v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  function automatic longint adj(input longint x, input longint sp, input longint sn);
    return (x >= sp) ? x + sn : x;
  endfunction

  // Reference frame: start sampled at end of cycle t0; events after stall point sp delayed by sn.
  task automatic push_frame(input longint t0, input longint g, input logic [3:0] m, input longint busy_s,
                            input bit last, input longint sp, input longint sn, output longint done_c);
    longint c;
    c = t0 + 1;
    push(K_CLR, c, RST_C);
    c += RST_C;
    if (g == 0) g = longint'(1) << GATE_W;
    push(K_GATE, c, g);
    c += g + SET_C;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        push(K_LATCH, adj(c, sp, sn), ch);
        c += 1 + SH_C;
      end
    end
    done_c = adj(c, sp, sn);
    push(K_DONE, done_c, 0);
    if (last) push(K_BUSY, busy_s, done_c + 1 - busy_s);
  endtask

  function automatic logic [3:0] eff(input logic [3:0] m);
    return HAS_MASK ? m : 4'hF;
  endfunction

  task automatic pulse_start(input logic [GATE_W-1:0] g, input logic [3:0] m, input bit scramble,
                             output longint t0);
    @(negedge clk);
    start = 1'b1;
    gate_len = g;
    chan_mask = m;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      gate_len = GATE_W'($urandom);
      chan_mask = 4'($urandom);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    check({name, "_idle_sel"}, 64'(counter_select), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctr_reset"}, 64'(ctr_reset), 64'd0);
    check({name, "_gate"}, 64'(gate), 64'd0);
    check({name, "_latch"}, 64'(latch_counter), 64'd0);
    check({name, "_sel"}, 64'(counter_select), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    longint t0, d1, d2, tr;
    int g1, g2;
    logic [3:0] m1, m2;
    logic [7:0] snap;

    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("after_reset");

    // Reference frame, gate_len=10
    pulse_start(16'd10, 4'hF, 1'b1, t0);
    push_frame(t0, 10, 4'hF, t0 + 1, 1'b1, NEVER, 0, d1);
    wait_drain(400, "basic");

    // gate_len=0 gives the full 2^GATE_W window
    pulse_start(16'd0, 4'hF, 1'b1, t0);
    push_frame(t0, 0, 4'hF, t0 + 1, 1'b1, NEVER, 0, d1);
    wait_drain(70000, "gate_zero");

    // Continuous: two back-to-back frames, second uses gate_len set mid-first-frame
    g1 = $urandom_range(1, 30);
    g2 = $urandom_range(1, 30);
    continuous = 1'b1;
    pulse_start(GATE_W'(g1), 4'hF, 1'b0, t0);
    gate_len = GATE_W'(g2);
    push_frame(t0, g1, 4'hF, t0 + 1, 1'b0, NEVER, 0, d1);
    push_frame(d1, g2, 4'hF, t0 + 1, 1'b1, NEVER, 0, d2);
    while (cyc < d1 + 10) @(negedge clk);
    continuous = 1'b0;
    wait_drain(600, "continuous");

    // start and gate_len toggled during GATE have no effect
    pulse_start(16'd20, 4'hF, 1'b1, t0);
    push_frame(t0, 20, 4'hF, t0 + 1, 1'b1, NEVER, 0, d1);
    while (cyc < t0 + 8) @(negedge clk);
    start = 1'b1;
    gate_len = GATE_W'($urandom_range(1, 500));
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_drain(400, "restart_ignored");

    // ena low for 5 cycles during SHIFT of channel 2
    pulse_start(16'd10, 4'hF, 1'b1, t0);
    push_frame(t0, 10, 4'hF, t0 + 1, 1'b1, t0 + 80, 5, d1);
    while (cyc < t0 + 79) @(negedge clk);
    snap = {ctr_reset, gate, latch_counter, counter_select, busy, frame_done, 1'b0};
    check("stall_sel", 64'(counter_select), 64'd2);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_frozen%0d", i), 64'({ctr_reset, gate, latch_counter, counter_select, busy, frame_done, 1'b0}), 64'(snap));
    end
    ena = 1'b1;
    wait_drain(400, "stall");

    // Reset asserted during SETTLE
    g1 = $urandom_range(5, 20);
    pulse_start(GATE_W'(g1), 4'hF, 1'b1, t0);
    tr = t0 + 6 + g1;
    push(K_CLR, t0 + 1, RST_C);
    push(K_GATE, t0 + 1 + RST_C, g1);
    push(K_BUSY, t0 + 1, tr - 1 - t0);
    while (cyc < tr - 1) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    wait_drain(10, "mid_reset");

`ifdef MEAS_SEQ_CHANNEL_MASK_EN
    pulse_start(16'd10, 4'b1010, 1'b1, t0);
    push_frame(t0, 10, 4'b1010, t0 + 1, 1'b1, NEVER, 0, d1);
    wait_drain(400, "mask_1010");
    pulse_start(16'd10, 4'b0000, 1'b1, t0);
    push_frame(t0, 10, 4'b0000, t0 + 1, 1'b1, NEVER, 0, d1);
    wait_drain(400, "mask_0");
`endif

    // Randomized frames, optionally chained
    for (int k = 0; k < 8; k++) begin
      g1 = $urandom_range(1, 40);
      g2 = $urandom_range(1, 40);
      m1 = 4'($urandom);
      m2 = 4'($urandom);
      continuous = 1'($urandom);
      pulse_start(GATE_W'(g1), m1, !continuous, t0);
      if (continuous) begin
        gate_len = GATE_W'(g2);
        chan_mask = m2;
        push_frame(t0, g1, eff(m1), t0 + 1, 1'b0, NEVER, 0, d1);
        push_frame(d1, g2, eff(m2), t0 + 1, 1'b1, NEVER, 0, d2);
        while (cyc < d1 + 3) @(negedge clk);
        continuous = 1'b0;
      end else begin
        push_frame(t0, g1, eff(m1), t0 + 1, 1'b1, NEVER, 0, d1);
      end
      wait_drain(600, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Measurement-window controller directly upstream of the ring-oscillator readout stage, in the clk domain.
- Generates ctr_reset, counter gate, latch_counter and counter_select, so one start pulse produces a complete four-channel measurement frame without further host pin wiggling.
- Clears all frequency counters, opens a gate window of programmable length, then latches and serially shifts each of the four counters in turn.

Parameters:
- GATE_W, 16, width of gate_len and the gate-window counter.
- RST_CYCLES, 4, cycles ctr_reset is held high; must be >=1.
- SETTLE_CYCLES, 4, cycles between gate close and the first latch, letting RO-domain counters settle; must be >=1.
- SHIFT_CYCLES, 24, cycles per channel for shift-out (COUNTER_LENGTH+4); must be >=1.

Ports:
- clk  input  1  system clock (readout clock).
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  design enable; low freezes the sequencer.
- start  input  1  level sampled each cycle; high in IDLE begins a frame.
- continuous  input  1  high: restart a new frame automatically after DONE.
- gate_len  input  GATE_W  gate window length in clk cycles; sampled on frame start.
- ctr_reset  output  1  counter clear to all fmeasurement channels.
- gate  output  1  counting window to all channels.
- latch_counter  output  1  one-cycle load strobe to the readout shift register.
- counter_select  output  2  channel index presented to the readout mux.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- All outputs registered, Moore-decoded from state; reset value of every output is 0; state goes to IDLE; channel index goes to 0.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH, SHIFT, DONE.
- IDLE: start=1 at posedge -> capture gate_len into gate_q, index=0 -> CLEAR next cycle.
- CLEAR: ctr_reset=1 for exactly RST_CYCLES cycles -> GATE.
- GATE: gate=1 for exactly gate_q cycles -> SETTLE.
  - gate_q==0 means 2^GATE_W cycles (full wrap, never zero-length).
- SETTLE: all strobes low for SETTLE_CYCLES cycles -> LATCH.
- LATCH: latch_counter=1 for exactly 1 cycle; counter_select=index -> SHIFT.
- SHIFT: SHIFT_CYCLES cycles, counter_select held at index.
  - Then: if index<3, index+1 -> LATCH; else -> DONE.
- DONE: frame_done=1 for 1 cycle; index cleared to 0.
  - Then: if continuous=1, recapture gate_len -> CLEAR; else -> IDLE.
- counter_select holds its last value outside LATCH/SHIFT; it is 0 after reset and after DONE.
- Frame length: RST_CYCLES + G + SETTLE_CYCLES + 4*(1+SHIFT_CYCLES) + 1 cycles; busy high for exactly that span.
- start while busy: ignored. gate_len changes mid-frame: no effect.
- continuous deasserted mid-frame: current frame completes, then IDLE.
- ena=0: all state and counters hold, outputs hold their values, one-cycle strobes included.
  - A frozen latch_counter or frame_done strobe remains high until ena returns, then lasts one further enabled cycle.
- reset asserted mid-frame: immediate return to IDLE, all outputs 0; no frame_done.
- ctr_reset, gate and latch_counter are never high in the same cycle.

Optional Feature:
- Macro MEAS_SEQ_CHANNEL_MASK_EN adds input chan_mask[3:0], sampled with gate_len.
- With macro:
  - LATCH/SHIFT are performed only for channels whose mask bit is 1, in ascending order.
  - Skipped channels take zero cycles.
  - chan_mask==0: SETTLE goes directly to DONE; frame_done still pulses.
- Without macro: all four channels are always read; port absent.

Test Plan:
- Reset, then a single start pulse with gate_len=10 and defaults:
  - ctr_reset high cycles 1-4, gate high cycles 5-14.
  - latch_counter pulses at cycles 19, 44, 69 and 94, with counter_select 0, 1, 2, 3.
  - frame_done at cycle 119; busy high for 119 cycles.
- gate_len=0 -> gate high for exactly 65536 cycles.
- continuous=1 for two frames, deassert during the second -> second frame starts the cycle after the first frame_done; IDLE after the second frame_done.
- start re-pulsed during GATE, and gate_len changed during GATE -> no restart, no change in gate length.
- ena low for 5 cycles during SHIFT of channel 2 -> outputs frozen; frame length extended by exactly 5 cycles.
- Reset asserted in SETTLE -> outputs 0 immediately; no frame_done.
- With MEAS_SEQ_CHANNEL_MASK_EN:
  - chan_mask=4'b1010 -> latches only counter_select 1 and 3; frame 50 cycles shorter.
  - chan_mask=0 -> frame_done immediately after SETTLE.
